// File: rtl/next_pc_pkg.sv
// Shared types and default addresses for the next-PC selector.
// Optional NEXT_PC_ALIGN_EN forces pc_out[1:0] to zero.
package next_pc_pkg;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_UNDO,
    SEL_INT,
    SEL_PCR,
    SEL_PCI,
    SEL_PRED,
    SEL_STALL,
    SEL_SEQ
  } pc_sel_e;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/next_pc_int_ctrl.sv
// Interrupt-pending latch and interrupt qualification.
// Converts a one-cycle alert into a single qualified interrupt.
module next_pc_int_ctrl
  import next_pc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic interrupt_mask,
  input  logic stall,
  input  logic branch_undo,
  input  logic alert,
  output logic interrupt
);

  logic pending_q;
  logic pending_d;

  assign interrupt = pending_q & ~interrupt_mask & ~stall
                   & ~branch_undo & ~rst;

  // alert wins over clear so a coincident request fires once more
  always_comb begin
    pending_d = pending_q;
    if (alert) begin
      pending_d = 1'b1;
    end else if (interrupt) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/next_pc_logic.sv
// Next fetch PC selector: priority encoder plus XLEN mux.
// Optional NEXT_PC_ALIGN_EN clears pc_out[1:0] after the mux.
module next_pc_logic
  import next_pc_pkg::*;
#(
  parameter int unsigned        XLEN       = 32,
  parameter logic [XLEN-1:0]    RESET_PC   = XLEN'(DEF_RESET_PC),
  parameter logic [XLEN-1:0]    INT_VECTOR = XLEN'(DEF_INT_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            interrupt_mask,
  input  logic            stall,
  input  logic            branch_predict,
  input  logic            pcr_take,
  input  logic            pci_take,
  input  logic            branch_undo,
  input  logic            alert,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] pc_not_taken,
  input  logic [XLEN-1:0] pci,
  input  logic [XLEN-1:0] pcr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus_4,
  output logic            interrupt,
  output logic [XLEN-1:0] pc_out
);

  pc_sel_e         sel;
  logic [XLEN-1:0] pc_mux;

  next_pc_int_ctrl u_int_ctrl (
    .clk            (clk),
    .rst            (rst),
    .interrupt_mask (interrupt_mask),
    .stall          (stall),
    .branch_undo    (branch_undo),
    .alert          (alert),
    .interrupt      (interrupt)
  );

  always_comb begin
    sel = SEL_SEQ;
    priority case (1'b1)
      rst:            sel = SEL_RESET;
      branch_undo:    sel = SEL_UNDO;
      interrupt:      sel = SEL_INT;
      pcr_take:       sel = SEL_PCR;
      pci_take:       sel = SEL_PCI;
      branch_predict: sel = SEL_PRED;
      stall:          sel = SEL_STALL;
      default:        sel = SEL_SEQ;
    endcase
  end

  always_comb begin
    pc_mux = pc_plus_4;
    unique case (sel)
      SEL_RESET: pc_mux = RESET_PC;
      SEL_UNDO:  pc_mux = pc_not_taken;
      SEL_INT:   pc_mux = INT_VECTOR;
      SEL_PCR:   pc_mux = pcr;
      SEL_PCI:   pc_mux = pci;
      SEL_PRED:  pc_mux = branch_pc;
      SEL_STALL: pc_mux = pc;
      SEL_SEQ:   pc_mux = pc_plus_4;
      default:   pc_mux = pc_plus_4;
    endcase
  end

`ifdef NEXT_PC_ALIGN_EN
  assign pc_out = pc_mux & ~XLEN'(3);
`else
  assign pc_out = pc_mux;
`endif

endmodule

// File: tb/tb_next_pc_logic.sv
// Directed self-checking bench for next_pc_logic.
// Expected PCs account for NEXT_PC_ALIGN_EN when defined.
module tb_next_pc_logic;

  logic        clk = 1'b0;
  logic        rst;
  logic        interrupt_mask;
  logic        stall;
  logic        branch_predict;
  logic        pcr_take;
  logic        pci_take;
  logic        branch_undo;
  logic        alert;
  logic [31:0] branch_pc;
  logic [31:0] pc_not_taken;
  logic [31:0] pci;
  logic [31:0] pcr;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        interrupt;
  logic [31:0] pc_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  next_pc_logic dut (
    .clk            (clk),
    .rst            (rst),
    .interrupt_mask (interrupt_mask),
    .stall          (stall),
    .branch_predict (branch_predict),
    .pcr_take       (pcr_take),
    .pci_take       (pci_take),
    .branch_undo    (branch_undo),
    .alert          (alert),
    .branch_pc      (branch_pc),
    .pc_not_taken   (pc_not_taken),
    .pci            (pci),
    .pcr            (pcr),
    .pc             (pc),
    .pc_plus_4      (pc_plus_4),
    .interrupt      (interrupt),
    .pc_out         (pc_out)
  );

  function automatic logic [31:0] al(input logic [31:0] v);
`ifdef NEXT_PC_ALIGN_EN
    return v & ~32'd3;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst            = 1'b0;
    interrupt_mask = 1'b0;
    stall          = 1'b0;
    branch_predict = 1'b0;
    pcr_take       = 1'b0;
    pci_take       = 1'b0;
    branch_undo    = 1'b0;
    alert          = 1'b0;
  endtask

  // inputs change 1 ns after the rising edge, outputs sampled on falling edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag,
                            input logic [31:0] epc,
                            input logic eint);
    @(negedge clk);
    check({tag, ".pc"}, pc_out, epc);
    check({tag, ".int"}, {31'd0, interrupt}, {31'd0, eint});
  endtask

  initial begin
    idle();
    branch_pc    = 32'd10;
    pc_not_taken = 32'd20;
    pci          = 32'd30;
    pcr          = 32'd40;
    pc           = 32'd0;
    pc_plus_4    = 32'd4;

    // reset, with an alert that must be ignored
    rst   = 1'b1;
    alert = 1'b1;
    expect_out("reset", 32'd0, 1'b0);
    next_cycle();
    idle();
    expect_out("post_reset", 32'd4, 1'b0);

    next_cycle();
    pc        = 32'h100;
    pc_plus_4 = 32'h104;
    stall     = 1'b1;
    expect_out("stall", 32'h100, 1'b0);
    next_cycle();
    idle();
    branch_predict = 1'b1;
    expect_out("predict", al(32'd10), 1'b0);
    next_cycle();
    stall = 1'b1;
    expect_out("predict_stall", al(32'd10), 1'b0);

    next_cycle();
    idle();
    pcr_take = 1'b1;
    expect_out("pcr", al(32'd40), 1'b0);
    next_cycle();
    idle();
    pci_take = 1'b1;
    expect_out("pci", al(32'd30), 1'b0);
    next_cycle();
    pcr_take = 1'b1;
    expect_out("pcr_pci", al(32'd40), 1'b0);
    next_cycle();
    idle();
    pcr_take    = 1'b1;
    branch_undo = 1'b1;
    expect_out("undo_pcr", al(32'd20), 1'b0);
    next_cycle();
    idle();
    expect_out("seq", 32'h104, 1'b0);

    // basic interrupt
    next_cycle();
    alert = 1'b1;
    expect_out("alert_same", 32'h104, 1'b0);
    next_cycle();
    idle();
    pcr_take = 1'b1;
    expect_out("int_fire", 32'h80, 1'b1);
    next_cycle();
    idle();
    expect_out("int_done", 32'h104, 1'b0);

    // masked then stalled, then released
    next_cycle();
    alert          = 1'b1;
    interrupt_mask = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("masked%0d", i), 32'h104, 1'b0);
      next_cycle();
      alert = 1'b0;
    end
    interrupt_mask = 1'b0;
    stall          = 1'b1;
    expect_out("unmask_stall", 32'h100, 1'b0);
    next_cycle();
    stall       = 1'b0;
    branch_undo = 1'b1;
    expect_out("undo_blocks", al(32'd20), 1'b0);
    next_cycle();
    idle();
    expect_out("int_release", 32'h80, 1'b1);
    next_cycle();
    expect_out("int_once", 32'h104, 1'b0);

    // alert coinciding with interrupt gives one more
    next_cycle();
    alert = 1'b1;
    expect_out("re_alert", 32'h104, 1'b0);
    next_cycle();
    expect_out("int_with_alert", 32'h80, 1'b1);
    next_cycle();
    idle();
    expect_out("int_again", 32'h80, 1'b1);
    next_cycle();
    expect_out("int_cleared", 32'h104, 1'b0);

    // reset clears a pending interrupt
    next_cycle();
    alert = 1'b1;
    expect_out("pend_pre_rst", 32'h104, 1'b0);
    next_cycle();
    idle();
    rst = 1'b1;
    expect_out("rst_blocks", 32'd0, 1'b0);
    next_cycle();
    idle();
    expect_out("rst_cleared", 32'h104, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
